alu_unit: RTL and testbench

- 16-bit ALU stage sitting directly upstream of the accumulator.
- Takes the current accumulator value (acc_in) and a second operand, and produces ALU_rez plus a one-cycle str_rez strobe. The accumulator latches the result on that strobe.
- Logic and add/sub ops complete in one cycle. MUL/DIV/MOD are iterative, 16 cycles, with a busy handshake.
- Status flags are registered alongside the result.

---
 rtl/alu_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// ALU stage feeding the accumulator: single-cycle add/sub/logic/shift/move ops and
// WIDTH-step iterative MUL/DIV/MOD, with a registered result, flags and a one-cycle store strobe.
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] ALU_rez,
  output logic             str_rez,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             div0
);

  localparam int            CW        = $clog2(WIDTH);
  localparam int            MSB       = WIDTH - 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_LSL = 4'h6,
    OP_LSR = 4'h7,
    OP_MUL = 4'h8,
    OP_DIV = 4'h9,
    OP_MOD = 4'hA
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    step_q, step_d;

  logic [WIDTH-1:0] rez_d;
  logic             str_d, zero_d, carry_d, ovf_d, div0_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the live operands
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    shamt;
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
  logic [WIDTH-1:0] sc_rez;
  logic             sc_carry, sc_ovf, sc_div0, sc_iter;

  assign shamt = op_b[CW-1:0];
  assign add_w = {1'b0, acc_in} + {1'b0, op_b};
  assign sub_w = {1'b0, acc_in} - {1'b0, op_b};
  // One guard bit on each shift catches the last bit shifted out (zero for a shift of 0).
  assign lsl_w = {1'b0, acc_in} << shamt;
  assign lsr_w = {acc_in, 1'b0} >> shamt;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    sc_rez   = op_b;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_div0  = 1'b0;
    sc_iter  = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_rez   = add_w[MSB:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (acc_in[MSB] == op_b[MSB]) && (add_w[MSB] != acc_in[MSB]);
      end
      OP_SUB: begin
        sc_rez   = sub_w[MSB:0];
        sc_carry = sub_w[WIDTH];
        sc_ovf   = (acc_in[MSB] != op_b[MSB]) && (sub_w[MSB] != acc_in[MSB]);
      end
      OP_AND: sc_rez = acc_in & op_b;
      OP_OR:  sc_rez = acc_in | op_b;
      OP_XOR: sc_rez = acc_in ^ op_b;
      OP_NOT: sc_rez = ~acc_in;
      OP_LSL: begin
        sc_rez   = lsl_w[MSB:0];
        sc_carry = lsl_w[WIDTH];
      end
      OP_LSR: begin
        sc_rez   = lsr_w[WIDTH:1];
        sc_carry = lsr_w[0];
      end
      OP_MUL: sc_iter = 1'b1;
      OP_DIV, OP_MOD: begin
        if (op_b == '0) begin
          sc_div0 = 1'b1;
          sc_rez  = (opcode == OP_DIV) ? '1 : acc_in;
        end else begin
          sc_iter = 1'b1;
        end
      end
      default: sc_rez = op_b;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration step: shift-add multiply or restoring divide on {hi, lo}
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {hi_q, lo_q[MSB]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];

  always_comb begin
    if (op_q == OP_MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[MSB:1]};
    end else begin
      it_hi = div_ge ? div_diff[MSB:0] : div_shift[MSB:0];
      it_lo = {lo_q[MSB-1:0], div_ge};
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state, next working registers and next result/flags
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    step_d  = step_q;
    rez_d   = ALU_rez;
    str_d   = 1'b0;
    zero_d  = zero;
    carry_d = carry;
    ovf_d   = ovf;
    div0_d  = div0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (sc_iter) begin
            state_d = ITER;
            op_d    = opcode;
            a_d     = acc_in;
            b_d     = op_b;
            hi_d    = '0;
            lo_d    = (opcode == OP_MUL) ? op_b : acc_in;
            step_d  = '0;
          end else begin
            str_d   = 1'b1;
            rez_d   = sc_rez;
            carry_d = sc_carry;
            ovf_d   = sc_ovf;
            div0_d  = sc_div0;
          end
        end
      end
      ITER: begin
        hi_d   = it_hi;
        lo_d   = it_lo;
        step_d = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          state_d = IDLE;
          str_d   = 1'b1;
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          carry_d = 1'b0;
          case (op_q)
            OP_MUL: begin
              rez_d   = it_lo;
              carry_d = |it_hi;
            end
            OP_DIV:  rez_d = it_lo;
            default: rez_d = it_hi;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (str_d) zero_d = (rez_d == '0);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      step_q  <= '0;
      ALU_rez <= '0;
      str_rez <= 1'b0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      div0    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      step_q  <= step_d;
      ALU_rez <= rez_d;
      str_rez <= str_d;
      zero    <= zero_d;
      carry   <= carry_d;
      ovf     <= ovf_d;
      div0    <= div0_d;
    end
  end

  assign busy = (state_q == ITER);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: expected results are queued when an operation is
// issued and compared, together with the strobe cycle, whenever str_rez rises.
module tb_alu_unit;

  typedef struct {
    string       name;
    logic [15:0] rez;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        div0;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] acc_in = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic [15:0] ALU_rez;
  logic        str_rez, busy, zero, carry, ovf, div0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .acc_in (acc_in),
    .op_b   (op_b),
    .ALU_rez(ALU_rez),
    .str_rez(str_rez),
    .busy   (busy),
    .zero   (zero),
    .carry  (carry),
    .ovf    (ovf),
    .div0   (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_iter(input logic [3:0] op, input logic [15:0] b);
    return (op == 4'h8) || ((op == 4'h9 || op == 4'hA) && b != 16'h0000);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa, sbv, r, s;
    logic [31:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    s   = int'(b[3:0]);
    e.name  = "";
    e.cyc   = 0;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.div0  = 1'b0;
    case (op)
      4'h0: begin
        e.rez = a + b;
        e.carry = (32'(a) + 32'(b)) > 32'hFFFF;
        r = sa + sbv;
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'h1: begin
        e.rez = a - b;
        e.carry = (a < b);
        r = sa - sbv;
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'h2: e.rez = a & b;
      4'h3: e.rez = a | b;
      4'h4: e.rez = a ^ b;
      4'h5: e.rez = ~a;
      4'h6: begin
        e.rez = a << s;
        e.carry = (s == 0) ? 1'b0 : a[16 - s];
      end
      4'h7: begin
        e.rez = a >> s;
        e.carry = (s == 0) ? 1'b0 : a[s - 1];
      end
      4'h8: begin
        p = 32'(a) * 32'(b);
        e.rez = p[15:0];
        e.carry = (p[31:16] != 16'h0000);
      end
      4'h9: begin
        e.div0 = (b == 16'h0000);
        e.rez = e.div0 ? 16'hFFFF : a / b;
      end
      4'hA: begin
        e.div0 = (b == 16'h0000);
        e.rez = e.div0 ? a : a % b;
      end
      default: e.rez = b;
    endcase
    e.zero = (e.rez == 16'h0000);
    return e;
  endfunction

  // Present an operation at the current negedge and queue what it must produce;
  // returns at the following negedge with start still asserted.
  task automatic drive(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(op, a, b);
    e.name = name;
    e.cyc = cyc + 1 + (is_iter(op, b) ? 16 : 0);
    sb.push_back(e);
    start = 1'b1;
    opcode = op;
    acc_in = a;
    op_b = b;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    drive(name, op, a, b);
    start = 1'b0;
    if (is_iter(op, b)) begin
      while (busy === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check({name, "_busy_cycles"}, n, 16);
    end else begin
      check({name, "_busy"}, 32'(busy), 0);
    end
    drain(name);
  endtask

  // Scoreboard consumer: every strobe must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (str_rez) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(str_rez), 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_rez"}, 32'(ALU_rez), 32'(mon_e.rez));
        check({mon_e.name, "_zero"}, 32'(zero), 32'(mon_e.zero));
        check({mon_e.name, "_carry"}, 32'(carry), 32'(mon_e.carry));
        check({mon_e.name, "_ovf"}, 32'(ovf), 32'(mon_e.ovf));
        check({mon_e.name, "_div0"}, 32'(div0), 32'(mon_e.div0));
        check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  logic [3:0]  t_op [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6, 4'h6, 4'hC};
  logic [15:0] t_a  [10] = '{16'h7FFF, 16'h0003, 16'hF0F0, 16'hF0F0, 16'hA5A5, 16'h00FF, 16'h0018, 16'h1234, 16'h0001, 16'h1111};
  logic [15:0] t_b  [10] = '{16'h0001, 16'h0005, 16'h3C3C, 16'h3C3C, 16'hA5A5, 16'h5555, 16'h0004, 16'h0000, 16'h000F, 16'hBEEF};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rez", 32'(ALU_rez), 0);
    check("reset_flags", {28'h0, zero, carry, ovf, div0}, 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_str", 32'(str_rez), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 4'h0, 16'hFFFF, 16'h0001);

    drive("sub_ovf", 4'h1, 16'h8000, 16'h0001);
    drive("lsl_out", 4'h6, 16'h8001, 16'h0001);
    start = 1'b0;
    drain("back_to_back");

    run_op("mul_ff", 4'h8, 16'h00FF, 16'h0101);
    run_op("mul_hi", 4'h8, 16'h0100, 16'h0100);

    drive("div", 4'h9, 16'h0064, 16'h0007);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("div_busy_mid", 32'(busy), 1);
    start = 1'b1;
    opcode = 4'h0;
    acc_in = 16'h1111;
    op_b = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    op_b = 16'h0002;
    drain("div");
    run_op("mod", 4'hA, 16'h0064, 16'h0007);

    run_op("div_by0", 4'h9, 16'h1234, 16'h0000);
    run_op("mod_by0", 4'hA, 16'h1234, 16'h0000);

    for (int i = 0; i < 10; i++) run_op($sformatf("single%0d", i), t_op[i], t_a[i], t_b[i]);
    for (int i = 0; i < 6; i++)
      run_op($sformatf("rnd%0d", i), 4'(8 + $urandom_range(0, 2)), 16'($urandom), 16'($urandom_range(1, 65535)));

    run_op("add_carry", 4'h0, 16'hFFFF, 16'h0002);
    drive("mul_abort", 4'h8, 16'h1234, 16'h0056);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_rez", 32'(ALU_rez), 0);
    check("abort_flags", {28'h0, zero, carry, ovf, div0}, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_str", 32'(str_rez), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 0);
    run_op("add_after_reset", 4'h0, 16'h1000, 16'h2345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
